// File: rtl/panel_loader.sv
// Front-panel program loader: streams (address, data) words into the panel via Load PC / Deposit presses,
// then loads the start PC and runs. Optional run watchdog: define PANEL_LOADER_WATCHDOG_EN.
module panel_loader #(
  parameter int WORD_W         = 12,
  parameter int SETUP_CYCLES   = 10,
  parameter int PRESS_CYCLES   = 10,
  parameter int RELEASE_CYCLES = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_addr,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic [WORD_W-1:0] start_pc,
  input  logic              run_led,
  output logic [WORD_W-1:0] sw_value,
  output logic              sw_run,
  output logic              load_pc_btn,
  output logic              deposit_btn,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_W = $clog2(max_of(max_of(SETUP_CYCLES, PRESS_CYCLES),
                                       max_of(RELEASE_CYCLES, TIMEOUT_CYCLES)) + 1);
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(RELEASE_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, LPC_SETUP, LPC_PRESS, LPC_REL, DEP_SETUP, DEP_PRESS, DEP_REL,
    START_SETUP, START_PRESS, START_REL, RUN_WAIT_HI, RUN_WAIT_LO, DONE
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] addr_q, data_q, start_pc_q, expected_addr;
  logic              last_q, first_word;
  logic              accept, lpc_needed, run_state, wd_fire;
  logic              setup_end, press_end, rel_end;

  assign in_ready    = (state == IDLE) || (state == DONE);
  assign accept      = in_valid && in_ready;
  assign lpc_needed  = first_word || (in_addr != expected_addr);
  assign run_state   = (state == RUN_WAIT_HI) || (state == RUN_WAIT_LO);
  assign setup_end   = (cnt == S_LAST);
  assign press_end   = (cnt == P_LAST);
  assign rel_end     = (cnt == R_LAST);

  assign load_pc_btn = (state == LPC_PRESS) || (state == START_PRESS);
  assign deposit_btn = (state == DEP_PRESS);
  assign sw_run      = run_state;
  assign busy        = !in_ready;
  assign done        = (state == DONE);

`ifdef PANEL_LOADER_WATCHDOG_EN
  logic timeout_q;
  assign wd_fire = run_state && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)      timeout_q <= 1'b0;
    else if (accept)  timeout_q <= 1'b0;
    else if (wd_fire) timeout_q <= 1'b1;
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE:  if (accept) state_n = lpc_needed ? LPC_SETUP : DEP_SETUP;
      LPC_SETUP:   if (setup_end) state_n = LPC_PRESS;
      LPC_PRESS:   if (press_end) state_n = LPC_REL;
      LPC_REL:     if (rel_end)   state_n = DEP_SETUP;
      DEP_SETUP:   if (setup_end) state_n = DEP_PRESS;
      DEP_PRESS:   if (press_end) state_n = DEP_REL;
      DEP_REL:     if (rel_end)   state_n = last_q ? START_SETUP : IDLE;
      START_SETUP: if (setup_end) state_n = START_PRESS;
      START_PRESS: if (press_end) state_n = START_REL;
      START_REL:   if (rel_end)   state_n = RUN_WAIT_HI;
      RUN_WAIT_HI: begin
        if (wd_fire)      state_n = DONE;
        else if (run_led) state_n = RUN_WAIT_LO;
      end
      RUN_WAIT_LO: if (wd_fire || !run_led) state_n = DONE;
      default:     state_n = IDLE;
    endcase
  end

  // The phase counter restarts on every state change except HI->LO, so the watchdog spans the whole run.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      cnt           <= '0;
      sw_value      <= '0;
      last_q        <= 1'b0;
      first_word    <= 1'b1;
      expected_addr <= '0;
    end else begin
      state <= state_n;
      if (state_n == IDLE || state_n == DONE)
        cnt <= '0;
      else if (state_n != state && state != RUN_WAIT_HI)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);

      if (accept)
        sw_value <= lpc_needed ? in_addr : in_data;
      else if (state == LPC_REL && state_n == DEP_SETUP)
        sw_value <= data_q;
      else if (state == DEP_REL && state_n == START_SETUP)
        sw_value <= start_pc_q;

      if (accept)
        last_q <= in_last;

      if (state == DEP_REL && state_n != DEP_REL) begin
        expected_addr <= addr_q + WORD_W'(1);
        first_word    <= 1'b0;
      end else if (state_n == DONE && state != DONE) begin
        first_word    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      addr_q <= in_addr;
      data_q <= in_data;
      if (in_last) start_pc_q <= start_pc;
    end
  end

endmodule

// File: doc/panel_loader.md
# panel_loader

Synthesizable front-panel program loader for the PDP-8 emulation top. It accepts a stream of (address, data) words over a valid/ready handshake and drives the Front_Panel switch and button inputs with parametrised setup, press and release timing. On a non-contiguous address it issues a Load PC before the deposit. After the last word it loads the start PC, raises the run switch, and waits for the run LED to fall. It replaces hand-coded testbench Load_PC/Deposit task sequences with a reusable block usable in emulation and on the board.

## Interface
Parameters:
- WORD_W, 12, width of address, data and switch value.
- SETUP_CYCLES, 10, cycles sw_value is stable before a button rises (≥1).
- PRESS_CYCLES, 10, cycles a button is held high (≥1).
- RELEASE_CYCLES, 10, cycles after button fall before the next action (≥1).
- TIMEOUT_CYCLES, 1000000, watchdog limit in RUN (used only with watchdog compiled in).

Ports:
- clock  in  1  system clock; one clock domain.
- resetN  in  1  asynchronous, active-low reset.
- in_valid  in  1  word available.
- in_ready  out  1  loader can accept a word.
- in_addr  in  WORD_W  target memory address.
- in_data  in  WORD_W  word to deposit.
- in_last  in  1  final word of image; qualifies with in_valid.
- start_pc  in  WORD_W  PC loaded before run; sampled when the last word is accepted.
- run_led  in  1  Front_Panel led[12]; high while CPU runs.
- sw_value  out  WORD_W  to Front_Panel sw[WORD_W-1:0].
- sw_run  out  1  to Front_Panel sw[12].
- load_pc_btn  out  1  to Front_Panel btnl.
- deposit_btn  out  1  to Front_Panel btnd.
- busy  out  1  session in progress (any state but IDLE/DONE).
- done  out  1  session finished; held in DONE.
- timeout  out  1  watchdog expired; sticky until next session.

## Operation
- States: IDLE, LPC_SETUP, LPC_PRESS, LPC_REL, DEP_SETUP, DEP_PRESS, DEP_REL, START_SETUP, START_PRESS, START_REL, RUN_WAIT_HI, RUN_WAIT_LO, DONE.
- Reset: all outputs 0 except in_ready=1 after reset release. State is IDLE; first_word=1; expected_addr=0.
- in_ready=1 only in IDLE and DONE; a transfer occurs on clock edge with in_valid&in_ready. Accepting in DONE starts a new session: done and timeout clear, first_word=1.
- On accept: latch addr/data/last (and start_pc if last). If first_word or in_addr≠expected_addr → LPC_SETUP with sw_value=in_addr, then DEP_SETUP. Else go directly to DEP_SETUP with sw_value=in_data.
- Each *_SETUP/PRESS/REL state lasts SETUP/PRESS/RELEASE_CYCLES. Its button is high only in *_PRESS. Entering DEP_SETUP loads sw_value=data.
- After DEP_REL: expected_addr=addr+1 mod 2^WORD_W, first_word=0. If not last → IDLE. Else → START_SETUP with sw_value=start_pc. START_PRESS pulses load_pc_btn.
- After START_REL: sw_run=1, RUN_WAIT_HI. When run_led=1 → RUN_WAIT_LO. When run_led=0 → DONE with sw_run=0 and done=1.
- in_valid while in_ready=0 is ignored; source holds data until accepted.

## Timing
- Accept at edge k (contiguous): sw_value valid after k. deposit_btn rises after edge k+S and falls after k+S+P. in_ready reasserts after k+S+P+R (S/P/R = SETUP/PRESS/RELEASE_CYCLES).
- Non-contiguous or first word: same sequence prefixed by a Load PC of S+P+R cycles; in_ready after k+2(S+P+R).
- Last word adds S+P+R for the start-PC load; sw_run rises the cycle after START_REL ends.
- Address 2^WORD_W−1 followed by 0 is contiguous (no Load PC).
- Buttons are never high simultaneously; sw_value never changes while a button is high.
- resetN low mid-operation: buttons, sw_run, busy, done and timeout clear immediately (asynchronously). The session is abandoned.

## Configuration
- PANEL_LOADER_WATCHDOG_EN defined: a counter runs in RUN_WAIT_HI/LO. At TIMEOUT_CYCLES it forces sw_run=0, timeout=1, done=1, and goes to DONE.
- Undefined: no counter; timeout tied 0; RUN waits indefinitely.

## Test plan
- Reset, words (0,1234),(1,5670 last), start_pc=0200 → load_pc_btn pulse with sw=0000, two deposit pulses, load_pc_btn with sw=0200, sw_run=1; drop run_led → done=1.
- Words at 0010, 0011, 0100 → Load PC issued only before 0010 and 0100; each button high exactly PRESS_CYCLES.
- Words 7777 then 0000 → single Load PC (7777); 0000 deposited without reload.
- Hold in_valid through a deposit → in_ready=0 for S+P+R cycles; word accepted once, not duplicated.
- Assert resetN=0 during DEP_PRESS → deposit_btn=0 same cycle; next session starts with Load PC.
- With PANEL_LOADER_WATCHDOG_EN, TIMEOUT_CYCLES=50, run_led stuck 1 → timeout=1, sw_run=0 at cycle 50; without macro timeout stays 0.
